// File: rtl/io_btn_in_if.sv
// IO bus bundle for io_btn_in: write port, read address and the read-mux chain data.
interface io_btn_in_if;
    // dma_io_we qualifies wadr/wdata for exactly one clock edge; there is no back-pressure.
    // dma_io_radr selects read data combinationally; rdata_in flows through on a miss.
    logic        dma_io_we;
    logic [15:2] dma_io_wadr;
    logic [31:0] dma_io_wdata;
    logic [15:2] dma_io_radr;
    logic [31:0] dma_io_rdata_in;
    logic [31:0] dma_io_rdata;

    modport master (
        output dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr, dma_io_rdata_in,
        input  dma_io_rdata
    );

    modport slave (
        input  dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr, dma_io_rdata_in,
        output dma_io_rdata
    );
endinterface

// File: rtl/io_btn_in.sv
// Four-channel button input: 2-flop sync, counter debounce, W1C press/release events, level IRQ.
// Optional feature macro: IO_BTN_IRQ_EN enables the IRQEN register and btn_irq.
module io_btn_in #(
    parameter int DB_CNT = 20000,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    io_btn_in_if.slave       bus,
    input  logic [3:0]       btn_in,
    output logic             btn_irq
);
    localparam logic [15:2]      ADR_LEVEL = 14'h3F84;
    localparam logic [15:2]      ADR_EVENT = 14'h3F85;
    localparam logic [15:2]      ADR_IRQEN = 14'h3F86;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DB_CNT - 1);

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_stable;
    logic [CNT_W-1:0] r_cnt [4];
    logic [7:0]       r_event;

    logic [3:0]       w_hit;
    logic [7:0]       w_set;
    logic [7:0]       w_clr;
    logic [7:0]       w_irqen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    // A channel flips on the DB_CNT-th consecutive cycle of disagreement.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < 4; i++) begin
            w_hit[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_LAST);
        end
    end

    // Press when the old level was 0, release when it was 1.
    assign w_set = {w_hit & r_stable, w_hit & ~r_stable};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_hit[i]) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_clr = (bus.dma_io_we && (bus.dma_io_wadr == ADR_EVENT)) ? bus.dma_io_wdata[7:0] : 8'h00;

    // Set is applied after clear so a simultaneous set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_event <= '0;
        end else begin
            r_event <= (r_event & ~w_clr) | w_set;
        end
    end

`ifdef IO_BTN_IRQ_EN
    logic [7:0] r_irqen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irqen <= '0;
        end else if (bus.dma_io_we && (bus.dma_io_wadr == ADR_IRQEN)) begin
            r_irqen <= bus.dma_io_wdata[7:0];
        end
    end

    assign w_irqen = r_irqen;
    assign btn_irq = |(r_event & r_irqen);
`else
    assign w_irqen = 8'h00;
    assign btn_irq = 1'b0;
`endif

    logic w_unused_wdata;
    assign w_unused_wdata = ^bus.dma_io_wdata[31:8];

    always_comb begin
        bus.dma_io_rdata = bus.dma_io_rdata_in;
        case (bus.dma_io_radr)
            ADR_LEVEL: bus.dma_io_rdata = {28'h0, r_stable};
            ADR_EVENT: bus.dma_io_rdata = {24'h0, r_event};
            ADR_IRQEN: bus.dma_io_rdata = {24'h0, w_irqen};
            default:   ;
        endcase
    end
endmodule

// File: tb/tb_io_btn_in.sv
// Self-checking bench for io_btn_in with DB_CNT=4; the reference model debounces with a sliding sample window.
module tb_io_btn_in;
    localparam int DB = 4;
    localparam logic [15:2] A_LEVEL = 14'h3F84;
    localparam logic [15:2] A_EVENT = 14'h3F85;
    localparam logic [15:2] A_IRQEN = 14'h3F86;
    localparam logic [15:2] A_OTHER = 14'h3F80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_in = 4'h0;
    logic       btn_irq;
    int         checks = 0;
    int         errors = 0;

    io_btn_in_if bus ();

    io_btn_in #(.DB_CNT(DB), .CNT_W(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .btn_in (btn_in),
        .btn_irq(btn_irq)
    );

    always #5 clk = ~clk;

    // Reference model: debounced level flips once the last DB delayed samples all differ from it.
    logic [3:0] m_stable;
    logic [7:0] m_event;
    logic [7:0] m_irqen;
    logic [3:0] win[$];

    task automatic model_reset();
        m_stable = '0;
        m_event  = '0;
        m_irqen  = '0;
        win.delete();
        for (int i = 0; i < DB + 2; i++) win.push_front(4'h0);
    endtask

    task automatic model_edge();
        logic [7:0] set;
        logic [7:0] clr;
        logic [3:0] nst;
        bit         all_diff;
        set = '0;
        clr = '0;
        nst = m_stable;
        win.push_front(btn_in);
        for (int c = 0; c < 4; c++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++) if (win[2 + j][c] == m_stable[c]) all_diff = 1'b0;
            if (all_diff) begin
                nst[c] = ~m_stable[c];
                if (m_stable[c]) set[c + 4] = 1'b1;
                else             set[c] = 1'b1;
            end
        end
        void'(win.pop_back());
        if (bus.dma_io_we && bus.dma_io_wadr == A_EVENT) clr = bus.dma_io_wdata[7:0];
`ifdef IO_BTN_IRQ_EN
        if (bus.dma_io_we && bus.dma_io_wadr == A_IRQEN) m_irqen = bus.dma_io_wdata[7:0];
`endif
        m_event  = (m_event & ~clr) | set;
        m_stable = nst;
    endtask

    function automatic logic exp_irq();
`ifdef IO_BTN_IRQ_EN
        return |(m_event & m_irqen);
`else
        return 1'b0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        btn_in = v;
        repeat (n) step();
    endtask

    task automatic wr(input logic [15:2] adr, input logic [31:0] data);
        bus.dma_io_we    = 1'b1;
        bus.dma_io_wadr  = adr;
        bus.dma_io_wdata = data;
        step();
        bus.dma_io_we    = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [15:2] adr, input logic [31:0] exp);
        bus.dma_io_radr     = adr;
        bus.dma_io_rdata_in = $urandom;
        #1;
        chk(tag, bus.dma_io_rdata, exp);
    endtask

    task automatic chk_model(input string tag);
        rd({tag, "_level"}, A_LEVEL, {28'h0, m_stable});
        rd({tag, "_event"}, A_EVENT, {24'h0, m_event});
        rd({tag, "_irqen"}, A_IRQEN, {24'h0, m_irqen});
        chk({tag, "_irq"}, {31'h0, btn_irq}, {31'h0, exp_irq()});
    endtask

    initial begin
        bus.dma_io_we       = 1'b0;
        bus.dma_io_wadr     = '0;
        bus.dma_io_wdata    = '0;
        bus.dma_io_radr     = '0;
        bus.dma_io_rdata_in = '0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset values and passthrough
        rd("rst_level", A_LEVEL, 32'h0);
        rd("rst_event", A_EVENT, 32'h0);
        rd("rst_irqen", A_IRQEN, 32'h0);
        chk("rst_irq", {31'h0, btn_irq}, 32'h0);
        bus.dma_io_radr = A_OTHER;
        bus.dma_io_rdata_in = 32'hDEADBEEF;
        #1;
        chk("passthru", bus.dma_io_rdata, 32'hDEADBEEF);
        rst_n = 1'b1;
        step();

        // Clean press on channel 2: level changes on the 6th edge after driving
        hold(4'h4, 5);
        rd("press2_early", A_LEVEL, 32'h0);
        step();
        rd("press2_level", A_LEVEL, 32'h4);
        rd("press2_event", A_EVENT, 32'h4);
        hold(4'h0, 8);
        rd("rel2_level", A_LEVEL, 32'h0);
        rd("rel2_event", A_EVENT, 32'h44);
        chk_model("rel2");
        wr(A_EVENT, 32'hFFFF_FFFF);
        rd("clr_all", A_EVENT, 32'h0);

        // Glitch rejection, then a pulse just long enough
        hold(4'h1, 3);
        hold(4'h0, 8);
        rd("glitch_level", A_LEVEL, 32'h0);
        rd("glitch_event", A_EVENT, 32'h0);
        hold(4'h1, 4);
        hold(4'h0, 3);
        rd("pulse4_event", A_EVENT, 32'h1);
        hold(4'h0, 8);
        chk_model("pulse4");
        wr(A_EVENT, 32'h0000_00FF);

        // Interrupt enable, press, then W1C drops the interrupt
        wr(A_IRQEN, 32'hFFFF_FF01);
        chk_model("irqen_wr");
        hold(4'h1, 8);
        chk_model("irq_press");
        wr(A_EVENT, 32'h1);
        rd("irq_w1c_event", A_EVENT, 32'h0);
        chk_model("irq_w1c");
        hold(4'h0, 8);
        wr(A_EVENT, 32'hFF);

        // W1C on the same edge a press on channel 1 latches: set wins
        btn_in = 4'h2;
        repeat (5) step();
        wr(A_EVENT, 32'h2);
        rd("setwins_event", A_EVENT, 32'h2);
        chk_model("setwins");

        // Reset mid-debounce drops the count and pending events
        hold(4'h8, 3);
        rst_n = 1'b0;
        model_reset();
        #1;
        rd("midrst_level", A_LEVEL, 32'h0);
        rd("midrst_event", A_EVENT, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        hold(4'hA, 8);
        chk_model("after_rst");

        // Randomized holds with occasional register writes
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 5))
                0: wr(A_EVENT, $urandom);
                1: wr(A_IRQEN, $urandom);
                2: wr(A_LEVEL, $urandom);
                default: hold(4'($urandom_range(0, 15)), $urandom_range(1, 7));
            endcase
            chk_model($sformatf("rand%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
